cv32e40p_tmr_err_collector: RTL and testbench

Consumer side of the TMR voter error vectors produced by the triplicated execution units (e.g. the 9-bit multiplier error vector). The block converts per-cycle voter mismatch flags into rising-edge fault events, and keeps per-source sticky flags and saturating event counters. It raises an alert when a source reaches a persistence threshold, and serialises pending events into a valid/ready report stream for the debug/status logic. It sits in the core top level next to the EX stage, one instance per TMR-protected unit.

---
 rtl/cv32e40p_tmr_err_collector_pkg.sv | 21 ++
 rtl/cv32e40p_tmr_err_collector_if.sv | 25 ++
 rtl/cv32e40p_tmr_err_counter.sv | 31 +++
 rtl/cv32e40p_tmr_err_collector.sv | 124 ++++++++++++
 tb/tb_cv32e40p_tmr_err_collector.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/cv32e40p_tmr_err_collector_pkg.sv
// Shared types for the TMR error collector: report FSM states and multiplier voter source indices.
// Constants only; no latency or backpressure of its own.
package cv32e40p_tmr_err_collector_pkg;

  typedef enum logic [0:0] {
    TMR_RPT_IDLE   = 1'b0,
    TMR_RPT_REPORT = 1'b1
  } tmr_rpt_state_e;

  // Bit positions inside the multiplier's 9-bit voter error vector
  localparam int unsigned TMR_MULT_MULTICYCLE  = 0;
  localparam int unsigned TMR_MULT_MULH_ACTIVE = 1;
  localparam int unsigned TMR_MULT_READY       = 2;
  localparam int unsigned TMR_MULT_INT_RES     = 3;
  localparam int unsigned TMR_MULT_SHORT_RES   = 4;
  localparam int unsigned TMR_MULT_DOT_CHAR    = 5;
  localparam int unsigned TMR_MULT_CLPX_SHIFT  = 6;
  localparam int unsigned TMR_MULT_DOT_SHORT   = 7;
  localparam int unsigned TMR_MULT_MULH_CS     = 8;

endpackage

// File: rtl/cv32e40p_tmr_err_collector_if.sv
// Fault report stream: the collector is master (drives valid and payload); the consumer returns ready.
// Payload is held stable while valid is high and no handshake has occurred.
interface cv32e40p_tmr_err_collector_if #(
  parameter int NUM_SRC   = 9,
  parameter int CNT_WIDTH = 8
);
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic                 rpt_valid_o;
  logic                 rpt_ready_i;
  logic [SRC_W-1:0]     rpt_src_o;
  logic [CNT_WIDTH-1:0] rpt_count_o;
  logic                 rpt_persistent_o;

  modport master (
    output rpt_valid_o, rpt_src_o, rpt_count_o, rpt_persistent_o,
    input  rpt_ready_i
  );

  modport slave (
    input  rpt_valid_o, rpt_src_o, rpt_count_o, rpt_persistent_o,
    output rpt_ready_i
  );

endinterface

// File: rtl/cv32e40p_tmr_err_counter.sv
// Per-source saturating event counter with its sticky bit; updates one cycle after ev.
// No backpressure; clear has priority over ev.
module cv32e40p_tmr_err_counter #(
  parameter int CNT_WIDTH = 8,
  parameter int THRESHOLD = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 ev,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 sticky,
  output logic                 ge_thr
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] THR     = CNT_WIDTH'(THRESHOLD);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt    <= '0;
      sticky <= 1'b0;
    end else if (ev) begin
      if (cnt != CNT_MAX) cnt <= cnt + CNT_WIDTH'(1);
      sticky <= 1'b1;
    end
  end

  assign ge_thr = (cnt >= THR);

endmodule

// File: rtl/cv32e40p_tmr_err_collector.sv
// Turns TMR voter mismatch flags into edge events, counts them per source and serialises reports.
// Report valid two cycles after a rising flag; payload held until ready, one report per two cycles.
module cv32e40p_tmr_err_collector
  import cv32e40p_tmr_err_collector_pkg::*;
#(
  parameter int NUM_SRC   = 9,
  parameter int CNT_WIDTH = 8,
  parameter int THRESHOLD = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_SRC-1:0]   tmr_err_i,
  input  logic                 enable_i,
  input  logic                 clear_i,
  output logic [NUM_SRC-1:0]   sticky_o,
  output logic                 alert_o,
  output logic                 irq_o,
  cv32e40p_tmr_err_collector_if.master rpt
);

  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] THR     = CNT_WIDTH'(THRESHOLD);

  logic [NUM_SRC-1:0]   err_q, ev, ge_thr, pending_q, pending_d, hs_clr;
  logic [CNT_WIDTH-1:0] cnt [NUM_SRC];
  logic                 irq_q, rearm_q, hs, sel_vld;
  logic [SRC_W-1:0]     sel_idx, src_q, src_d;
  logic [CNT_WIDTH-1:0] sel_cnt, count_q, count_d;
  tmr_rpt_state_e       state_q, state_d;

  assign ev = {NUM_SRC{enable_i}} & tmr_err_i & ~err_q;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_cnt
    cv32e40p_tmr_err_counter #(
      .CNT_WIDTH (CNT_WIDTH),
      .THRESHOLD (THRESHOLD)
    ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .clear  (clear_i),
      .ev     (ev[k]),
      .cnt    (cnt[k]),
      .sticky (sticky_o[k]),
      .ge_thr (ge_thr[k])
    );
  end

  assign alert_o = |ge_thr;
  assign irq_o   = irq_q;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    count_d = count_q;
    hs      = 1'b0;
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (pending_q[k]) begin
        sel_vld = 1'b1;
        sel_idx = SRC_W'(k);
      end
    end
    // Snapshot includes an increment landing in the same cycle
    sel_cnt = cnt[sel_idx];
    if (ev[sel_idx] && (sel_cnt != CNT_MAX)) sel_cnt = sel_cnt + CNT_WIDTH'(1);
    case (state_q)
      TMR_RPT_IDLE: begin
        if (sel_vld) begin
          state_d = TMR_RPT_REPORT;
          src_d   = sel_idx;
          count_d = sel_cnt;
        end
      end
      TMR_RPT_REPORT: begin
        if (rpt.rpt_ready_i) begin
          hs      = 1'b1;
          state_d = TMR_RPT_IDLE;
        end
      end
      default: state_d = TMR_RPT_IDLE;
    endcase
  end

  // A source re-firing while its report is in flight keeps its pending bit for a fresh report
  always_comb begin
    hs_clr = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      hs_clr[k] = hs && !rearm_q && (src_q == SRC_W'(k));
    end
    pending_d = (pending_q & ~hs_clr) | ev;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= '0;
    else     err_q <= tmr_err_i;
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      state_q   <= TMR_RPT_IDLE;
      src_q     <= '0;
      count_q   <= '0;
      pending_q <= '0;
      irq_q     <= 1'b0;
      rearm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      irq_q     <= |(ev & ~sticky_o);
      if (state_q == TMR_RPT_REPORT && !hs) rearm_q <= rearm_q | ev[src_q];
      else                                  rearm_q <= 1'b0;
    end
  end

  assign rpt.rpt_valid_o      = (state_q == TMR_RPT_REPORT);
  assign rpt.rpt_src_o        = src_q;
  assign rpt.rpt_count_o      = count_q;
  assign rpt.rpt_persistent_o = (count_q >= THR);

endmodule

// File: tb/tb_cv32e40p_tmr_err_collector.sv
// Directed bench for the TMR error collector: default instance plus a 2-bit-counter instance for saturation.
module tb_cv32e40p_tmr_err_collector;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] err_a, err_b;
  logic       en_a, en_b, clr_a, clr_b;
  logic [8:0] sticky_a, sticky_b;
  logic       alert_a, alert_b, irq_a, irq_b;
  int         checks = 0;
  int         errors = 0;
  int         extra, bad;

  always #5 clk = ~clk;

  cv32e40p_tmr_err_collector_if #(.NUM_SRC(9), .CNT_WIDTH(8)) rpt_a ();
  cv32e40p_tmr_err_collector_if #(.NUM_SRC(9), .CNT_WIDTH(2)) rpt_b ();

  cv32e40p_tmr_err_collector #(.NUM_SRC(9), .CNT_WIDTH(8), .THRESHOLD(4)) dut_a (
    .clk (clk), .rst (rst), .tmr_err_i (err_a), .enable_i (en_a), .clear_i (clr_a),
    .sticky_o (sticky_a), .alert_o (alert_a), .irq_o (irq_a), .rpt (rpt_a.master)
  );

  cv32e40p_tmr_err_collector #(.NUM_SRC(9), .CNT_WIDTH(2), .THRESHOLD(3)) dut_b (
    .clk (clk), .rst (rst), .tmr_err_i (err_b), .enable_i (en_b), .clear_i (clr_b),
    .sticky_o (sticky_b), .alert_o (alert_b), .irq_o (irq_b), .rpt (rpt_b.master)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    err_a = '0; err_b = '0; en_a = 1'b1; en_b = 1'b1; clr_a = 1'b0; clr_b = 1'b0;
    rpt_a.rpt_ready_i = 1'b1;
    rpt_b.rpt_ready_i = 1'b1;
    step(); step();
    chk("rst_sticky", 32'(sticky_a), 32'h0);
    chk("rst_alert", 32'(alert_a), 32'h0);
    chk("rst_irq", 32'(irq_a), 32'h0);
    chk("rst_valid", 32'(rpt_a.rpt_valid_o), 32'h0);
    chk("rst_src", 32'(rpt_a.rpt_src_o), 32'h0);
    chk("rst_count", 32'(rpt_a.rpt_count_o), 32'h0);
    chk("rst_pers", 32'(rpt_a.rpt_persistent_o), 32'h0);
    rst = 1'b0;
    step();

    // Single stuck fault on source 3
    err_a = 9'h008;
    step();
    chk("t1_sticky", 32'(sticky_a), 32'h008);
    chk("t1_irq", 32'(irq_a), 32'h1);
    chk("t1_valid_early", 32'(rpt_a.rpt_valid_o), 32'h0);
    chk("t1_alert", 32'(alert_a), 32'h0);
    step();
    chk("t1_irq_off", 32'(irq_a), 32'h0);
    chk("t1_valid", 32'(rpt_a.rpt_valid_o), 32'h1);
    chk("t1_src", 32'(rpt_a.rpt_src_o), 32'h3);
    chk("t1_count", 32'(rpt_a.rpt_count_o), 32'h1);
    chk("t1_pers", 32'(rpt_a.rpt_persistent_o), 32'h0);
    step();
    chk("t1_valid_done", 32'(rpt_a.rpt_valid_o), 32'h0);
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      extra += int'(rpt_a.rpt_valid_o) + int'(irq_a);
    end
    chk("t1_no_extra", 32'(extra), 32'h0);
    err_a = 9'h000;
    step();

    // Simultaneous faults on sources 0 and 8
    err_a = 9'h101;
    step();
    err_a = 9'h000;
    chk("t2_sticky", 32'(sticky_a), 32'h109);
    chk("t2_irq", 32'(irq_a), 32'h1);
    step();
    chk("t2_v0", 32'(rpt_a.rpt_valid_o), 32'h1);
    chk("t2_src0", 32'(rpt_a.rpt_src_o), 32'h0);
    chk("t2_cnt0", 32'(rpt_a.rpt_count_o), 32'h1);
    step();
    chk("t2_gap", 32'(rpt_a.rpt_valid_o), 32'h0);
    step();
    chk("t2_v8", 32'(rpt_a.rpt_valid_o), 32'h1);
    chk("t2_src8", 32'(rpt_a.rpt_src_o), 32'h8);
    chk("t2_cnt8", 32'(rpt_a.rpt_count_o), 32'h1);
    step();
    chk("t2_done", 32'(rpt_a.rpt_valid_o), 32'h0);

    // Threshold: four toggles on source 5
    for (int i = 1; i <= 4; i++) begin
      err_a = 9'h020;
      step();
      chk("t3_irq", 32'(irq_a), 32'(i == 1));
      err_a = 9'h000;
      step();
      chk("t3_valid", 32'(rpt_a.rpt_valid_o), 32'h1);
      chk("t3_src", 32'(rpt_a.rpt_src_o), 32'h5);
      chk("t3_count", 32'(rpt_a.rpt_count_o), 32'(i));
      chk("t3_pers", 32'(rpt_a.rpt_persistent_o), 32'(i >= 4));
      chk("t3_alert", 32'(alert_a), 32'(i >= 4));
    end
    step();
    chk("t3_done", 32'(rpt_a.rpt_valid_o), 32'h0);

    // Backpressure on source 2 with a second event during the stall
    rpt_a.rpt_ready_i = 1'b0;
    err_a = 9'h004;
    step();
    err_a = 9'h000;
    step();
    chk("t4_valid", 32'(rpt_a.rpt_valid_o), 32'h1);
    chk("t4_src", 32'(rpt_a.rpt_src_o), 32'h2);
    chk("t4_count", 32'(rpt_a.rpt_count_o), 32'h1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      err_a = (i == 3) ? 9'h004 : 9'h000;
      step();
      if (!(rpt_a.rpt_valid_o === 1'b1 && rpt_a.rpt_src_o === 4'h2 &&
            rpt_a.rpt_count_o === 8'h01 && rpt_a.rpt_persistent_o === 1'b0)) bad++;
    end
    err_a = 9'h000;
    chk("t4_stable", 32'(bad), 32'h0);
    chk("t4_sticky", 32'(sticky_a), 32'h12d);
    rpt_a.rpt_ready_i = 1'b1;
    step();
    chk("t4_accept", 32'(rpt_a.rpt_valid_o), 32'h0);
    step();
    chk("t4_rerpt_valid", 32'(rpt_a.rpt_valid_o), 32'h1);
    chk("t4_rerpt_src", 32'(rpt_a.rpt_src_o), 32'h2);
    chk("t4_rerpt_count", 32'(rpt_a.rpt_count_o), 32'h2);
    step();
    step();
    chk("t4_done", 32'(rpt_a.rpt_valid_o), 32'h0);

    // Clear while a report is stalled, with a fault in the clear cycle
    rpt_a.rpt_ready_i = 1'b0;
    err_a = 9'h040;
    step();
    err_a = 9'h000;
    step();
    chk("t5_valid", 32'(rpt_a.rpt_valid_o), 32'h1);
    chk("t5_src", 32'(rpt_a.rpt_src_o), 32'h6);
    chk("t5_alert_pre", 32'(alert_a), 32'h1);
    clr_a = 1'b1;
    err_a = 9'h080;
    step();
    clr_a = 1'b0;
    chk("t5_valid_clr", 32'(rpt_a.rpt_valid_o), 32'h0);
    chk("t5_sticky_clr", 32'(sticky_a), 32'h0);
    chk("t5_alert_clr", 32'(alert_a), 32'h0);
    chk("t5_irq_clr", 32'(irq_a), 32'h0);
    step(); step();
    chk("t5_fault_dropped", 32'(sticky_a), 32'h0);
    chk("t5_no_report", 32'(rpt_a.rpt_valid_o), 32'h0);
    err_a = 9'h000;
    rpt_a.rpt_ready_i = 1'b1;
    step();

    // Enable low suppresses detection but edge history keeps tracking
    en_a = 1'b0;
    err_a = 9'h010;
    step();
    chk("t6_disabled", 32'(sticky_a), 32'h0);
    en_a = 1'b1;
    step();
    chk("t6_no_late_edge", 32'(sticky_a), 32'h0);
    chk("t6_no_irq", 32'(irq_a), 32'h0);
    err_a = 9'h000;
    step();
    err_a = 9'h010;
    step();
    err_a = 9'h000;
    chk("t6_reenabled", 32'(sticky_a), 32'h010);
    step(); step();

    // Saturation on the 2-bit-counter instance
    for (int i = 1; i <= 5; i++) begin
      err_b = 9'h001;
      step();
      err_b = 9'h000;
      step();
      chk("t7_valid", 32'(rpt_b.rpt_valid_o), 32'h1);
      chk("t7_src", 32'(rpt_b.rpt_src_o), 32'h0);
      chk("t7_count", 32'(rpt_b.rpt_count_o), 32'((i < 3) ? i : 3));
      chk("t7_pers", 32'(rpt_b.rpt_persistent_o), 32'(i >= 3));
    end
    step();
    chk("t7_done", 32'(rpt_b.rpt_valid_o), 32'h0);
    chk("t7_alert", 32'(alert_b), 32'h1);
    chk("t7_sticky", 32'(sticky_b), 32'h001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
